// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   if_state_e       : fetch FSM encodings IF_IDLE / IF_FETCH / IF_VALID (2 bits)
//   TRUE / FALSE     : single-bit flag constants
//   INST_W / BYTE_W  : instruction width and memory-port byte width
//   ICACHE_LINES_DEF : default line count of the optional instruction cache
package if_fetch_pkg;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_VALID = 2'd2
  } if_state_e;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int INST_W = 32;
  localparam int BYTE_W = 8;

  localparam int ICACHE_LINES_DEF = 64;

endpackage

// File: rtl/if_fetch_if.sv
// Byte-wide read port between the fetch stage and the memory controller.
//   mem_req_o  : byte read request (fetch -> memory)
//   mem_addr_o : byte address      (fetch -> memory)
//   mem_ack_i  : request accepted, mem_data_i valid this cycle (memory -> fetch)
//   mem_data_i : returned byte     (memory -> fetch)
// Modports: master = fetch stage, slave = memory controller.
interface if_fetch_if #(
  parameter int ADDR_W = 32
);
  import if_fetch_pkg::*;

  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ack_i;
  logic [BYTE_W-1:0] mem_data_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_data_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_data_i
  );

endinterface

// File: rtl/if_icache.sv
// Direct-mapped, one-word-per-line instruction cache (built only with ICACHE_EN).
// Addresses arrive as word addresses (byte address >> 2).
//   clk, rst      : clock, asynchronous active-high reset (clears valid bits)
//   lookup_waddr  : word address looked up combinationally
//   hit           : lookup_waddr is present
//   lookup_data   : cached word for lookup_waddr (meaningful when hit)
//   fill_en       : write fill_data into the line selected by fill_waddr
//   fill_waddr    : word address being filled
//   fill_data     : instruction word to store
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int LINES  = ICACHE_LINES_DEF,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-3:0] lookup_waddr,
  output logic              hit,
  output logic [INST_W-1:0] lookup_data,
  input  logic              fill_en,
  input  logic [ADDR_W-3:0] fill_waddr,
  input  logic [INST_W-1:0] fill_data
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [INST_W-1:0] data_mem [LINES];

  logic [IDX_W-1:0] l_idx, f_idx;
  logic [TAG_W-1:0] l_tag, f_tag;

  assign l_idx = lookup_waddr[IDX_W-1:0];
  assign l_tag = lookup_waddr[ADDR_W-3:IDX_W];
  assign f_idx = fill_waddr[IDX_W-1:0];
  assign f_tag = fill_waddr[ADDR_W-3:IDX_W];

  assign hit         = valid_q[l_idx] && (tag_mem[l_idx] == l_tag);
  assign lookup_data = data_mem[l_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[f_idx] <= TRUE;
    end
  end

  // NOTE: tag/data arrays are deliberately left out of reset; the valid bits
  // alone make stale contents invisible, and un-reset arrays map onto RAM.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[f_idx]  <= f_tag;
      data_mem[f_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles each 32-bit instruction from four
// little-endian byte reads and hands it, with its PC, to the IF/ID register.
// Optional feature macro: ICACHE_EN (adds a direct-mapped instruction cache).
//   clk, rst     : clock, asynchronous active-high reset
//   rdy          : global ready; when low every register holds
//   pc_i         : current PC from pc_reg
//   stall_i      : IF/ID not accepting
//   jump_i       : one-cycle redirect pulse from EX
//   mem          : byte read port (if_fetch_if.master)
//   inst_o       : fetched instruction
//   inst_pc_o    : PC of inst_o
//   inst_valid_o : inst_o / inst_pc_o valid
//   if_stall_o   : fetch busy, pc_reg and IF/ID must hold
// All outputs are decoded from registered state only, so no input reaches an
// output combinationally. if_stall_o is high whenever the stage is not
// presenting an instruction, including right after reset.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ICACHE_LINES = ICACHE_LINES_DEF,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              stall_i,
  input  logic              jump_i,
  if_fetch_if.master        mem,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  output logic              if_stall_o
);

  if_state_e         state;
  logic [1:0]        cnt;        // byte index within the word being fetched
  logic              discard_q;  // a redirect arrived; drop this fetch
  logic [ADDR_W-1:0] fpc;
  logic [INST_W-1:0] inst_q;

  logic              cache_hit;
  logic [INST_W-1:0] cache_data;

`ifdef ICACHE_EN
  logic fill_en;

  // Fill only on the last byte of a fetch that is not being thrown away,
  // including a redirect arriving together with that last ack.
  assign fill_en = rdy && (state == IF_FETCH) && mem.mem_ack_i &&
                   (cnt == 2'd3) && !discard_q && !jump_i;

  if_icache #(
    .LINES  (ICACHE_LINES),
    .ADDR_W (ADDR_W)
  ) u_icache (
    .clk          (clk),
    .rst          (rst),
    .lookup_waddr (pc_i[ADDR_W-1:2]),
    .hit          (cache_hit),
    .lookup_data  (cache_data),
    .fill_en      (fill_en),
    .fill_waddr   (fpc[ADDR_W-1:2]),
    .fill_data    ({mem.mem_data_i, inst_q[INST_W-BYTE_W-1:0]})
  );
`else
  assign cache_hit  = FALSE;
  assign cache_data = '0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IF_IDLE;
      cnt       <= 2'd0;
      discard_q <= FALSE;
      fpc       <= '0;
      inst_q    <= '0;
    end else if (rdy) begin
      unique case (state)
        IF_IDLE: begin
          // During a redirect pulse pc_i still shows the old PC; wait it out.
          if (!jump_i) begin
            fpc <= pc_i;
            if (cache_hit) begin
              inst_q <= cache_data;
              state  <= IF_VALID;
            end else begin
              cnt   <= 2'd0;
              state <= IF_FETCH;
            end
          end
        end
        IF_FETCH: begin
          if (mem.mem_ack_i) begin
            inst_q[cnt*BYTE_W +: BYTE_W] <= mem.mem_data_i;
            cnt <= cnt + 2'd1;
            // The accepted byte completes the outstanding request; a pending
            // or coincident redirect then abandons the word.
            if (discard_q || jump_i) begin
              discard_q <= FALSE;
              state     <= IF_IDLE;
            end else if (cnt == 2'd3) begin
              state <= IF_VALID;
            end
          end else if (jump_i) begin
            discard_q <= TRUE;
          end
        end
        IF_VALID: begin
          if (jump_i || !stall_i) begin
            state <= IF_IDLE;
          end
        end
        default: state <= IF_IDLE;
      endcase
    end
  end

  assign mem.mem_req_o  = (state == IF_FETCH);
  assign mem.mem_addr_o = fpc + ADDR_W'(cnt);

  assign inst_o       = inst_q;
  assign inst_pc_o    = fpc;
  assign inst_valid_o = (state == IF_VALID);
  assign if_stall_o   = (state != IF_VALID);

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch. Inputs change 1 time unit after the rising
// edge; outputs are compared at that same point, well away from the next edge.
// With ICACHE_EN defined the second fetch of 0x40 is expected to hit the cache.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] pc_i;
  logic        stall_i;
  logic        jump_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        if_stall_o;

  int vectors     = 0;
  int miscompares = 0;

  if_fetch_if #(.ADDR_W(32)) mem_if ();

  if_fetch #(
    .ICACHE_LINES (64),
    .ADDR_W       (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .pc_i         (pc_i),
    .stall_i      (stall_i),
    .jump_i       (jump_i),
    .mem          (mem_if.master),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_valid_o (inst_valid_o),
    .if_stall_o   (if_stall_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stage is in FETCH at addr; hold off the ack for wait_cyc cycles, then ack.
  task automatic byte_ack(input string tag, input logic [31:0] addr,
                          input logic [7:0] d, input int wait_cyc);
    for (int i = 0; i < wait_cyc; i++) begin
      check({tag, " req(wait)"}, 32'(mem_if.mem_req_o), 32'd1);
      check({tag, " addr(wait)"}, mem_if.mem_addr_o, addr);
      tick();
    end
    check({tag, " req"}, 32'(mem_if.mem_req_o), 32'd1);
    check({tag, " addr"}, mem_if.mem_addr_o, addr);
    check({tag, " stall"}, 32'(if_stall_o), 32'd1);
    mem_if.mem_ack_i  = 1'b1;
    mem_if.mem_data_i = d;
    tick();
    mem_if.mem_ack_i  = 1'b0;
  endtask

  task automatic check_valid(input string tag, input logic [31:0] inst, input logic [31:0] pc);
    check({tag, " valid"}, 32'(inst_valid_o), 32'd1);
    check({tag, " stall"}, 32'(if_stall_o), 32'd0);
    check({tag, " req"}, 32'(mem_if.mem_req_o), 32'd0);
    check({tag, " inst"}, inst_o, inst);
    check({tag, " pc"}, inst_pc_o, pc);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " valid"}, 32'(inst_valid_o), 32'd0);
    check({tag, " stall"}, 32'(if_stall_o), 32'd1);
    check({tag, " req"}, 32'(mem_if.mem_req_o), 32'd0);
  endtask

  initial begin
    rst               = 1'b1;
    rdy               = 1'b1;
    pc_i              = 32'h0;
    stall_i           = 1'b0;
    jump_i            = 1'b0;
    mem_if.mem_ack_i  = 1'b0;
    mem_if.mem_data_i = 8'h00;
    tick();
    tick();

    // Reset state.
    check("rst inst", inst_o, 32'h0);
    check("rst pc", inst_pc_o, 32'h0);
    check("rst addr", mem_if.mem_addr_o, 32'h0);
    check_idle("rst");
    rst = 1'b0;

    // 1: back-to-back acks from 0x0, VALID in cycle 5.
    check_idle("t1 idle");
    tick();
    byte_ack("t1 b0", 32'h0, 8'h13, 0);
    byte_ack("t1 b1", 32'h1, 8'h05, 0);
    byte_ack("t1 b2", 32'h2, 8'h00, 0);
    byte_ack("t1 b3", 32'h3, 8'h00, 0);
    check_valid("t1", 32'h0000_0513, 32'h0);
    tick();
    check_idle("t1 after");

    // 2: each ack delayed 3 cycles from 0x1000.
    pc_i = 32'h1000;
    tick();
    byte_ack("t2 b0", 32'h1000, 8'h93, 3);
    byte_ack("t2 b1", 32'h1001, 8'h00, 3);
    byte_ack("t2 b2", 32'h1002, 8'h10, 3);
    byte_ack("t2 b3", 32'h1003, 8'h00, 3);
    check_valid("t2", 32'h0010_0093, 32'h1000);

    // 3: downstream stall holds VALID.
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_valid("t3 hold", 32'h0010_0093, 32'h1000);
    end
    stall_i = 1'b0;
    tick();
    check_idle("t3 release");

    // 4: redirect while counter=1; outstanding byte finishes, no VALID.
    pc_i = 32'h3000;
    tick();
    byte_ack("t4 b0", 32'h3000, 8'hAA, 0);
    jump_i = 1'b1;
    check("t4 jump addr", mem_if.mem_addr_o, 32'h3001);
    tick();
    jump_i = 1'b0;
    pc_i   = 32'h2000;
    byte_ack("t4 b1", 32'h3001, 8'hBB, 1);
    check_idle("t4 discarded");
    tick();
    byte_ack("t4 n0", 32'h2000, 8'hB7, 0);
    byte_ack("t4 n1", 32'h2001, 8'h02, 0);
    byte_ack("t4 n2", 32'h2002, 8'h00, 0);
    byte_ack("t4 n3", 32'h2003, 8'h00, 0);
    check_valid("t4", 32'h0000_02B7, 32'h2000);
    tick();
    check_idle("t4 after");

    // 5: rdy low mid-fetch with an ack attempted; it must be ignored.
    pc_i = 32'h5000;
    tick();
    byte_ack("t5 b0", 32'h5000, 8'h11, 0);
    rdy               = 1'b0;
    mem_if.mem_ack_i  = 1'b1;
    mem_if.mem_data_i = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5 frozen addr", mem_if.mem_addr_o, 32'h5001);
      check("t5 frozen req", 32'(mem_if.mem_req_o), 32'd1);
    end
    rdy              = 1'b1;
    mem_if.mem_ack_i = 1'b0;
    byte_ack("t5 b1", 32'h5001, 8'h22, 0);
    byte_ack("t5 b2", 32'h5002, 8'h33, 0);
    byte_ack("t5 b3", 32'h5003, 8'h44, 0);
    check_valid("t5", 32'h4433_2211, 32'h5000);

    // Redirect in VALID wins over a held stall.
    stall_i = 1'b1;
    jump_i  = 1'b1;
    tick();
    stall_i = 1'b0;
    jump_i  = 1'b0;
    check_idle("jv");

    // 6: fetch 0x40 twice.
    pc_i = 32'h40;
    tick();
    byte_ack("t6 b0", 32'h40, 8'h13, 0);
    byte_ack("t6 b1", 32'h41, 8'h01, 0);
    byte_ack("t6 b2", 32'h42, 8'h40, 0);
    byte_ack("t6 b3", 32'h43, 8'h00, 0);
    check_valid("t6 first", 32'h0040_0113, 32'h40);
    tick();
    check_idle("t6 idle");
    tick();
`ifdef ICACHE_EN
    check_valid("t6 hit", 32'h0040_0113, 32'h40);
`else
    byte_ack("t6 r0", 32'h40, 8'h13, 0);
    byte_ack("t6 r1", 32'h41, 8'h01, 0);
    byte_ack("t6 r2", 32'h42, 8'h40, 0);
    byte_ack("t6 r3", 32'h43, 8'h00, 0);
    check_valid("t6 refetch", 32'h0040_0113, 32'h40);
`endif
    tick();
    check_idle("t6 after");

    // Redirect coincident with the final ack: no VALID and no cache fill.
    pc_i = 32'h80;
    tick();
    byte_ack("jf b0", 32'h80, 8'h01, 0);
    byte_ack("jf b1", 32'h81, 8'h02, 0);
    byte_ack("jf b2", 32'h82, 8'h03, 0);
    jump_i = 1'b1;
    byte_ack("jf b3", 32'h83, 8'h04, 0);
    jump_i = 1'b0;
    check_idle("jf discarded");
    tick();
    byte_ack("jf r0", 32'h80, 8'h01, 0);
    byte_ack("jf r1", 32'h81, 8'h02, 0);
    byte_ack("jf r2", 32'h82, 8'h03, 0);
    byte_ack("jf r3", 32'h83, 8'h04, 0);
    check_valid("jf refetch", 32'h0403_0201, 32'h80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
